mvmul_tile_sched: RTL and testbench

- Issue scheduler for the 36-lane 6x6 matrix-vector FP multiply datapath. The datapath is fully pipelined and has no result backpressure.
- Accepts a frame of NUM_TILES 6x6 tiles, each with its 6-element vector slice, from an upstream streaming source. Issues at most one tile per cycle to the datapath.
- Reserves output buffer space before every issue, so the datapath never produces a result it cannot store. Results are returned in order through a valid/ready output buffer.

---
 rtl/mvmul_pkg.sv | 14 +
 rtl/mvmul_res_fifo.sv | 50 +++++
 rtl/mvmul_tile_sched.sv | 153 +++++++++++++++
 tb/tb_mvmul_tile_sched.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mvmul_pkg.sv
// Shared widths and FSM state encoding for the 6x6 matrix-vector multiply tile scheduler.
package mvmul_pkg;
    localparam int unsigned FP_W  = 32;
    localparam int unsigned MV_N  = 6;
    localparam int unsigned MAT_W = FP_W * MV_N * MV_N;
    localparam int unsigned VEC_W = FP_W * MV_N;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } sched_state_t;
endpackage

// File: rtl/mvmul_res_fifo.sv
// Synchronous first-word-fall-through FIFO; head reads as zero while empty.
module mvmul_res_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned W     = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic [W-1:0]           wr_data,
    input  logic                   rd_en,
    output logic [W-1:0]           rd_data,
    output logic [$clog2(DEPTH):0] count
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          empty;
    logic          full;
    logic          do_wr;
    logic          do_rd;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_rd   = rd_en && !empty;
    assign do_wr   = wr_en && (!full || do_rd);
    assign rd_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + AW'(1);
            if (do_rd) rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(do_wr) - CW'(do_rd);
        end
    end

    // Storage carries no reset; the empty gate above hides stale entries.
    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= wr_data;
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(wr_en && full && !rd_en));
endmodule

// File: rtl/mvmul_tile_sched.sv
// Credit-based issue scheduler for the 6x6 FP matrix-vector datapath.
// Define MVMUL_SCHED_PERF_EN to add the stall/busy performance counters.
module mvmul_tile_sched
    import mvmul_pkg::*;
#(
    parameter int unsigned MUL_LATENCY = 8,
    parameter int unsigned FIFO_DEPTH  = 16,
    parameter int unsigned TAG_W       = 8,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] num_tiles,
    output logic             busy,
    output logic             done,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [MAT_W-1:0] s_mat,
    input  logic [VEC_W-1:0] s_vec,
    input  logic [TAG_W-1:0] s_tag,
    output logic [MAT_W-1:0] dp_mat,
    output logic [VEC_W-1:0] dp_vec,
    input  logic [MAT_W-1:0] dp_res,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [MAT_W-1:0] m_data,
    output logic [TAG_W-1:0] m_tag,
`ifdef MVMUL_SCHED_PERF_EN
    output logic [31:0]      perf_stall_cnt,
    output logic [31:0]      perf_busy_cnt,
`endif
    output logic             m_last
);
    localparam int unsigned SR_LEN = MUL_LATENCY + 1;
    localparam int unsigned CR_W   = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned RES_W  = TAG_W + 1 + MAT_W;

    sched_state_t      state_q;
    sched_state_t      state_d;
    logic [CNT_W-1:0]  num_q;
    logic [CNT_W-1:0]  issued_q;
    logic [CNT_W-1:0]  issued_d;
    logic [CNT_W-1:0]  wr_cnt_q;
    logic [CR_W-1:0]   credits_q;
    logic [CR_W-1:0]   credits_d;
    logic [SR_LEN-1:0] infl_q;
    logic              issue;
    logic              pop;
    logic              res_wr;
    logic              res_last;
    logic [TAG_W-1:0]  tag_head;
    logic [RES_W-1:0]  res_head;
    logic [CR_W-1:0]   res_count;
    logic [CR_W-1:0]   tag_count;

    assign issue     = s_valid && s_ready;
    assign m_valid   = (res_count != '0);
    assign pop       = m_valid && m_ready;
    assign res_wr    = infl_q[SR_LEN-1];
    assign res_last  = ((wr_cnt_q + CNT_W'(1)) == num_q);
    assign credits_d = credits_q - CR_W'(issue) + CR_W'(pop);
    assign issued_d  = issued_q + CNT_W'(issue);

    assign m_tag  = res_head[RES_W-1 -: TAG_W];
    assign m_last = res_head[MAT_W];
    assign m_data = res_head[MAT_W-1:0];

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (start) state_d = (num_tiles == '0) ? ST_DONE : ST_RUN;
            ST_RUN:   if (issue && (issued_d == num_q)) state_d = ST_DRAIN;
            ST_DRAIN: if ((infl_q == '0) && (res_count == '0)) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            num_q     <= '0;
            issued_q  <= '0;
            wr_cnt_q  <= '0;
            credits_q <= CR_W'(FIFO_DEPTH);
            infl_q    <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            s_ready   <= 1'b0;
            dp_mat    <= '0;
            dp_vec    <= '0;
        end else begin
            state_q   <= state_d;
            busy      <= (state_d != ST_IDLE);
            done      <= (state_d == ST_DONE);
            s_ready   <= (state_d == ST_RUN) && (credits_d != '0);
            credits_q <= credits_d;
            infl_q    <= {infl_q[SR_LEN-2:0], issue};
            issued_q  <= issued_d;
            if (issue) begin
                dp_mat <= s_mat;
                dp_vec <= s_vec;
            end
            if ((state_q == ST_IDLE) && start) begin
                num_q    <= num_tiles;
                issued_q <= '0;
                wr_cnt_q <= '0;
            end else if (res_wr) begin
                wr_cnt_q <= wr_cnt_q + CNT_W'(1);
            end
        end
    end

    // Tags wait here while their tile is in the datapath.
    mvmul_res_fifo #(.DEPTH(FIFO_DEPTH), .W(TAG_W)) u_tag_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (issue),
        .wr_data (s_tag),
        .rd_en   (res_wr),
        .rd_data (tag_head),
        .count   (tag_count)
    );

    mvmul_res_fifo #(.DEPTH(FIFO_DEPTH), .W(RES_W)) u_res_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (res_wr),
        .wr_data ({tag_head, res_last, dp_res}),
        .rd_en   (pop),
        .rd_data (res_head),
        .count   (res_count)
    );

    a_credit_sum: assert property (@(posedge clk) disable iff (rst)
        (32'(credits_q) + 32'(res_count) + 32'($countones(infl_q))) == 32'(FIFO_DEPTH));
    a_tag_track: assert property (@(posedge clk) disable iff (rst)
        32'(tag_count) == 32'($countones(infl_q)));

`ifdef MVMUL_SCHED_PERF_EN
    always_ff @(posedge clk) begin
        if (rst || ((state_q == ST_IDLE) && start)) begin
            perf_stall_cnt <= '0;
            perf_busy_cnt  <= '0;
        end else begin
            if (busy && (perf_busy_cnt != '1)) perf_busy_cnt <= perf_busy_cnt + 32'd1;
            if ((state_q == ST_RUN) && s_valid && !s_ready && (perf_stall_cnt != '1))
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_mvmul_tile_sched.sv
// Randomized bench for mvmul_tile_sched with a behavioural datapath and in-order result scoreboard.
`timescale 1ns/1ps
module tb_mvmul_tile_sched;
    import mvmul_pkg::*;

    localparam int ML    = 8;
    localparam int DEPTH = 16;
    localparam int TAG_W = 8;
    localparam int CNT_W = 16;

    typedef struct {
        logic [TAG_W-1:0] tag;
        logic             last;
        logic [MAT_W-1:0] data;
        int               hs_cyc;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [CNT_W-1:0] num_tiles = '0;
    logic             busy, done, s_ready, m_valid, m_last;
    logic             s_valid = 1'b0;
    logic             m_ready = 1'b0;
    logic [MAT_W-1:0] s_mat = '0;
    logic [VEC_W-1:0] s_vec = '0;
    logic [TAG_W-1:0] s_tag = '0;
    logic [MAT_W-1:0] dp_mat, dp_res, m_data;
    logic [VEC_W-1:0] dp_vec;
    logic [TAG_W-1:0] m_tag;
`ifdef MVMUL_SCHED_PERF_EN
    logic [31:0]      perf_stall_cnt, perf_busy_cnt;
`endif

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;

    mvmul_tile_sched #(
        .MUL_LATENCY (ML),
        .FIFO_DEPTH  (DEPTH),
        .TAG_W       (TAG_W),
        .CNT_W       (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .num_tiles (num_tiles),
        .busy      (busy),
        .done      (done),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_mat     (s_mat),
        .s_vec     (s_vec),
        .s_tag     (s_tag),
        .dp_mat    (dp_mat),
        .dp_vec    (dp_vec),
        .dp_res    (dp_res),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .m_tag     (m_tag),
`ifdef MVMUL_SCHED_PERF_EN
        .perf_stall_cnt (perf_stall_cnt),
        .perf_busy_cnt  (perf_busy_cnt),
`endif
        .m_last    (m_last)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Single-precision <-> real for exactly representable small integers.
    function automatic real s2r(input logic [FP_W-1:0] s);
        if (s[30:0] == 31'd0) return 0.0;
        return $bitstoreal({s[31], 11'(s[30:23]) + 11'd896, s[22:0], 29'd0});
    endfunction

    function automatic logic [FP_W-1:0] r2s(input real r);
        logic [63:0] b;
        b = $realtobits(r);
        if (r == 0.0) return '0;
        return {b[63], 8'(b[62:52] - 11'd896), b[51:29]};
    endfunction

    // P[k] = M[k] * V[k/6]
    function automatic logic [MAT_W-1:0] mv_ref(input logic [MAT_W-1:0] m, input logic [VEC_W-1:0] v);
        logic [MAT_W-1:0] p;
        for (int k = 0; k < 36; k++)
            p[k*FP_W +: FP_W] = r2s(s2r(m[k*FP_W +: FP_W]) * s2r(v[(k/6)*FP_W +: FP_W]));
        return p;
    endfunction

    function automatic int elem_mism(input logic [MAT_W-1:0] a, input logic [MAT_W-1:0] b);
        int n = 0;
        for (int k = 0; k < 36; k++)
            if (a[k*FP_W +: FP_W] !== b[k*FP_W +: FP_W]) n++;
        return n;
    endfunction

    function automatic logic [FP_W-1:0] rand_elem();
        return r2s(real'(int'($urandom_range(30))) - 15.0);
    endfunction

    // Behavioural datapath: fixed ML-cycle pipeline of the products.
    logic [MAT_W-1:0] pipe [ML];
    always @(posedge clk) begin
        pipe[0] <= mv_ref(dp_mat, dp_vec);
        for (int i = 1; i < ML; i++) pipe[i] <= pipe[i-1];
    end
    assign dp_res = pipe[ML-1];

    task automatic new_tile(input logic [TAG_W-1:0] tag);
        for (int k = 0; k < 36; k++) s_mat[k*FP_W +: FP_W] = rand_elem();
        for (int j = 0; j < 6; j++)  s_vec[j*FP_W +: FP_W] = rand_elem();
        s_tag = tag;
    endtask

    task automatic run_frame(input int n, input int sv_pct, input int mr_pct, input int hold,
                             input bit lat_chk, input int max_cyc, input int tag_base);
        exp_t q[$];
        exp_t e;
        int   offered = 0, done_cnt = 0, busy_cyc = 0, stall_exp = 0, max_out = 0;
        bit   fin = 0, hold_prev = 0, sready_seen = 0, hs = 0, hs_last = 0, pop = 0;
        logic [TAG_W-1:0] prev_tag = '0;
        logic [MAT_W-1:0] prev_data = '0;

        @(negedge clk);
        start = 1'b1;
        num_tiles = CNT_W'(n);
        @(negedge clk);
        start = 1'b0;
        check("start_busy", busy, 1);
`ifdef MVMUL_SCHED_PERF_EN
        check("perf_clr_stall", perf_stall_cnt, 0);
        check("perf_clr_busy", perf_busy_cnt, 0);
`endif
        for (int c = 0; c < max_cyc && !fin; c++) begin
            if (c > 0) @(negedge clk);
            busy_cyc += int'(busy);
            if (s_ready) sready_seen = 1;
            if (hold_prev) begin
                check("hold_valid", m_valid, 1);
                check("hold_tag", m_tag, prev_tag);
                check("hold_data", elem_mism(m_data, prev_data), 0);
            end
            if (hold > 0 && c == hold) begin
                check("hold_accepted", offered, DEPTH);
                check("hold_sready", s_ready, 0);
`ifdef MVMUL_SCHED_PERF_EN
                check("perf_stall", perf_stall_cnt, stall_exp);
`endif
            end
            if (done) begin
                done_cnt++;
                fin = 1;
            end
            m_ready = (c >= hold) && (int'($urandom_range(99)) < mr_pct);
            if (hs_last) s_valid = 1'b0;
            if (!s_valid && offered < n && int'($urandom_range(99)) < sv_pct) begin
                new_tile(TAG_W'(tag_base + offered));
                s_valid = 1'b1;
            end
            hs  = s_valid && s_ready;
            pop = m_valid && m_ready;
            if (busy && s_valid && !s_ready) stall_exp++;
            if (pop) begin
                check("result_expected", q.size() != 0, 1);
                if (q.size() != 0) begin
                    e = q.pop_front();
                    check("tag", m_tag, e.tag);
                    check("last", m_last, e.last);
                    check("data", elem_mism(m_data, e.data), 0);
                    if (lat_chk) check("latency", cyc - e.hs_cyc, ML + 2);
                end
            end
            if (hs) begin
                e.tag    = s_tag;
                e.last   = (offered + 1 == n);
                e.data   = mv_ref(s_mat, s_vec);
                e.hs_cyc = cyc;
                q.push_back(e);
                offered++;
            end
            if (q.size() > max_out) max_out = q.size();
            hold_prev = m_valid && !m_ready;
            prev_tag  = m_tag;
            prev_data = m_data;
            hs_last   = hs;
        end
        s_valid = 1'b0;
        m_ready = 1'b0;
        check("done_pulses", done_cnt, 1);
        check("accepted", offered, n);
        check("leftover", q.size(), 0);
        check("outstanding_le_depth", max_out <= DEPTH, 1);
        if (n == 0) check("sready_empty_frame", sready_seen, 0);
        @(negedge clk);
        check("busy_drop", busy, 0);
        check("done_single", done, 0);
`ifdef MVMUL_SCHED_PERF_EN
        check("perf_busy", perf_busy_cnt, busy_cyc);
`endif
    endtask

    task automatic check_reset_outputs(input string pfx);
        check({pfx, "_busy"}, busy, 0);
        check({pfx, "_done"}, done, 0);
        check({pfx, "_s_ready"}, s_ready, 0);
        check({pfx, "_m_valid"}, m_valid, 0);
        check({pfx, "_m_last"}, m_last, 0);
        check({pfx, "_m_tag"}, m_tag, 0);
        check({pfx, "_m_data"}, |m_data, 0);
        check({pfx, "_dp_mat"}, |dp_mat, 0);
        check({pfx, "_dp_vec"}, |dp_vec, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        int seen_mv;
        int seen_done;

        repeat (3) @(negedge clk);
        check_reset_outputs("rst");
        rst = 1'b0;

        run_frame(4, 100, 100, 0, 1, 200, 'h10);     // back-to-back, fixed latency
        run_frame(40, 100, 100, 40, 0, 1000, 0);     // fill buffer with m_ready low
        run_frame(100, 50, 50, 0, 0, 3000, 0);       // random both sides
        run_frame(20, 100, 100, 60, 0, 1000, 'h40);  // stall accounting
        run_frame(0, 100, 100, 0, 0, 50, 0);         // empty frame

        // Reset with tiles in flight.
        @(negedge clk);
        start = 1'b1;
        num_tiles = CNT_W'(10);
        @(negedge clk);
        start = 1'b0;
        m_ready = 1'b1;
        acc = 0;
        for (int i = 0; i < 5; i++) begin
            new_tile(TAG_W'(i));
            s_valid = 1'b1;
            if (s_ready) acc++;
            @(negedge clk);
        end
        s_valid = 1'b0;
        check("midrst_accepted", acc, 5);
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("midrst");
        rst = 1'b0;
        seen_mv = 0;
        seen_done = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            seen_mv += int'(m_valid);
            seen_done += int'(done);
        end
        check("midrst_no_mvalid", seen_mv, 0);
        check("midrst_no_done", seen_done, 0);
        m_ready = 1'b0;
        run_frame(2, 100, 100, 0, 1, 200, 'h80);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end
endmodule
